// File: rtl/led_frame_packer.sv
// Zone-to-LED frame packer: snapshots per-zone means on start and streams LEDS_PER_ZONE words per zone into a FIFO.
// Optional build macro LED_DIM_EN adds a dim input that scales every channel by (dim+1)/2^CW.
module led_frame_packer #(
  parameter int NZONE         = 8,
  parameter int CW            = 4,
  parameter int LEDS_PER_ZONE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic [NZONE*CW-1:0] mean_r,
  input  logic [NZONE*CW-1:0] mean_g,
  input  logic [NZONE*CW-1:0] mean_b,
  input  logic [1:0]          mode,
`ifdef LED_DIM_EN
  input  logic [CW-1:0]       dim,
`endif
  input  logic                fifo_full,
  output logic                we,
  output logic [3*CW-1:0]     fifo_data,
  output logic                send_start,
  output logic                busy,
  output logic                frame_drop
);

  localparam int LW = (LEDS_PER_ZONE > 1) ? $clog2(LEDS_PER_ZONE) : 1;
  localparam int VW = $clog2(2 * NZONE);
  localparam int ZW = (NZONE > 1) ? $clog2(NZONE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LOAD, S_PACK, S_DONE} state_e;
  typedef enum logic [1:0] {M_FWD, M_REV, M_MIRROR, M_SOLID} mode_e;

  state_e              state_q, state_d;
  mode_e               mode_q;
  logic [LW-1:0]       led_cnt_q, led_cnt_d;
  logic [VW-1:0]       zone_cnt_q, zone_cnt_d;   // visit index, up to 2*NZONE in mirror
  logic [NZONE*CW-1:0] r_q, g_q, b_q;
  logic                frame_drop_q;
  logic                snap;
  logic [ZW-1:0]       zone_idx;
  logic [CW-1:0]       ch_r, ch_g, ch_b;
  logic                last_led, last_visit;

`ifdef LED_DIM_EN
  logic [CW-1:0] dim_q;

  function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [CW-1:0] d);
    logic [2*CW:0] p;
    p = (2*CW+1)'(c) * ((2*CW+1)'(d) + (2*CW+1)'(1));
    return p[2*CW-1:CW];
  endfunction
`endif

  // Map the visit counter onto a physical zone according to the latched order.
  always_comb begin
    int v, z;
    v = int'(zone_cnt_q);
    z = 0;
    case (mode_q)
      M_FWD:    z = v;
      M_REV:    z = NZONE - 1 - v;
      M_MIRROR: z = (v < NZONE) ? v : (2 * NZONE - 1 - v);
      default:  z = 0;
    endcase
    zone_idx = ZW'(z);
  end

  always_comb begin
`ifdef LED_DIM_EN
    ch_r = scale(r_q[zone_idx*CW +: CW], dim_q);
    ch_g = scale(g_q[zone_idx*CW +: CW], dim_q);
    ch_b = scale(b_q[zone_idx*CW +: CW], dim_q);
`else
    ch_r = r_q[zone_idx*CW +: CW];
    ch_g = g_q[zone_idx*CW +: CW];
    ch_b = b_q[zone_idx*CW +: CW];
`endif
  end

  assign last_led   = (led_cnt_q == LW'(LEDS_PER_ZONE - 1));
  assign last_visit = (mode_q == M_MIRROR) ? (zone_cnt_q == VW'(2 * NZONE - 1))
                                           : (zone_cnt_q == VW'(NZONE - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    led_cnt_d  = led_cnt_q;
    zone_cnt_d = zone_cnt_q;
    snap       = 1'b0;
    we         = 1'b0;
    send_start = 1'b0;
    busy       = 1'b0;
    fifo_data  = '0;
    case (state_q)
      S_IDLE:  if (en) state_d = S_ARMED;
      S_ARMED: if (start) begin
        state_d = S_LOAD;
        snap    = 1'b1;
      end
      S_LOAD: begin
        busy       = 1'b1;
        led_cnt_d  = '0;
        zone_cnt_d = '0;
        state_d    = S_PACK;
      end
      S_PACK: begin
        busy      = 1'b1;
        we        = !fifo_full;
        fifo_data = {ch_r, ch_g, ch_b};
        if (we) begin
          if (last_led) begin
            led_cnt_d = '0;
            if (last_visit) state_d = S_DONE;
            else            zone_cnt_d = zone_cnt_q + 1'b1;
          end else begin
            led_cnt_d = led_cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        send_start = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_drop = frame_drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= M_FWD;
      led_cnt_q    <= '0;
      zone_cnt_q   <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      frame_drop_q <= 1'b0;
`ifdef LED_DIM_EN
      dim_q        <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
      state_q      <= state_d;
      led_cnt_q    <= led_cnt_d;
      zone_cnt_q   <= zone_cnt_d;
      frame_drop_q <= start && busy;
      if (snap) begin
        r_q    <= mean_r;
        g_q    <= mean_g;
        b_q    <= mean_b;
        mode_q <= mode_e'(mode);
`ifdef LED_DIM_EN
        dim_q  <= dim;
`endif
      end
    end
  end

endmodule

// File: tb/tb_led_frame_packer.sv
// Self-checking bench for led_frame_packer: directed frames plus randomized frames against a queue-based word model.
module tb_led_frame_packer;
  localparam int NZ  = 8;
  localparam int CW  = 4;
  localparam int LPZ = 4;

  logic             clk = 1'b0;
  logic             rst, en, start, fifo_full;
  logic [NZ*CW-1:0] mean_r, mean_g, mean_b;
  logic [1:0]       mode;
  logic [CW-1:0]    dim_v;
  logic             we, send_start, busy, frame_drop;
  logic [3*CW-1:0]  fifo_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];

  led_frame_packer #(.NZONE(NZ), .CW(CW), .LEDS_PER_ZONE(LPZ)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .mean_r(mean_r), .mean_g(mean_g), .mean_b(mean_b), .mode(mode),
`ifdef LED_DIM_EN
    .dim(dim_v),
`endif
    .fifo_full(fifo_full), .we(we), .fifo_data(fifo_data),
    .send_start(send_start), .busy(busy), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected word stream: visit order from the mode rules, each visit repeated LPZ times.
  task automatic build(input int md);
    int nvis, z, cr, cg, cb;
    exp_q.delete();
    nvis = (md == 2) ? 2 * NZ : NZ;
    for (int v = 0; v < nvis; v++) begin
      case (md)
        0: z = v;
        1: z = NZ - 1 - v;
        2: z = (v < NZ) ? v : 2 * NZ - 1 - v;
        default: z = 0;
      endcase
      cr = int'(mean_r[z*CW +: CW]);
      cg = int'(mean_g[z*CW +: CW]);
      cb = int'(mean_b[z*CW +: CW]);
`ifdef LED_DIM_EN
      cr = (cr * (int'(dim_v) + 1)) / 16;
      cg = (cg * (int'(dim_v) + 1)) / 16;
      cb = (cb * (int'(dim_v) + 1)) / 16;
`endif
      for (int k = 0; k < LPZ; k++) exp_q.push_back(12'((cr << 8) | (cg << 4) | cb));
    end
  endtask

  task automatic run_frame(input string tag, input int md, input int stall_at, input int drop_at,
                           input bit rnd_full, input bit scramble, input bit pre_armed);
    int idx, cyc, first_we, last_we, ss_cyc, drops, stall_left;
    bit drop_done;
    idx = 0; cyc = 0; first_we = -1; last_we = -1; ss_cyc = -1; drops = 0; stall_left = 3; drop_done = 0;
    got_q.delete();
    build(md);
    if (!pre_armed) begin
      @(negedge clk); en = 1'b1;
    end
    @(negedge clk); en = 1'b0; start = 1'b1; mode = 2'(md);
    while (ss_cyc < 0 && cyc < 600) begin
      @(negedge clk);
      start = 1'b0;
      if (drop_at >= 0 && !drop_done && idx == drop_at) begin
        start = 1'b1; drop_done = 1'b1;
      end
      if (stall_at >= 0 && idx == stall_at && stall_left > 0) begin
        fifo_full = 1'b1; stall_left--;
      end else if (rnd_full) fifo_full = ($urandom_range(0, 3) == 0);
      else fifo_full = 1'b0;
      if (scramble) begin
        mean_r = $urandom; mean_g = $urandom; mean_b = $urandom; mode = 2'($urandom_range(0, 3));
`ifdef LED_DIM_EN
        dim_v = 4'($urandom);
`endif
      end
      #1;
      if (fifo_full) check({tag, " we under full"}, 32'(we), 0);
      if (we) begin
        if (first_we < 0) first_we = cyc;
        if (idx < exp_q.size()) check($sformatf("%s word%0d", tag, idx), 32'(fifo_data), 32'(exp_q[idx]));
        else check({tag, " extra word"}, idx, exp_q.size());
        got_q.push_back(fifo_data);
        last_we = cyc;
        idx++;
      end
      if (frame_drop) drops++;
      if (send_start) ss_cyc = cyc;
      cyc++;
    end
    if (ss_cyc < 0) check({tag, " timeout waiting send_start"}, 1, 0);
    check({tag, " word count"}, idx, exp_q.size());
    check({tag, " send_start after last word"}, ss_cyc, last_we + 1);
    if (!rnd_full && stall_at != 0) check({tag, " first we latency"}, first_we, 1);
    @(negedge clk); start = 1'b0; fifo_full = 1'b0; #1;
    if (frame_drop) drops++;
    check({tag, " idle busy"}, 32'(busy), 0);
    check({tag, " single send_start"}, 32'(send_start), 0);
    check({tag, " frame_drop pulses"}, drops, (drop_at >= 0) ? 1 : 0);
  endtask

  task automatic ramp_means();
    for (int z = 0; z < NZ; z++) begin
      mean_r[z*CW +: CW] = CW'(z);
      mean_g[z*CW +: CW] = 4'hF;
      mean_b[z*CW +: CW] = 4'h0;
    end
  endtask

  initial begin
    int n, guard, bad;
    rst = 1'b1; en = 1'b0; start = 1'b0; fifo_full = 1'b0; mode = 2'b00; dim_v = 4'hF;
    mean_r = '0; mean_g = '0; mean_b = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset we", 32'(we), 0);
    check("reset send_start", 32'(send_start), 0);
    check("reset busy", 32'(busy), 0);
    check("reset frame_drop", 32'(frame_drop), 0);
    check("reset fifo_data", 32'(fifo_data), 0);
    @(negedge clk); rst = 1'b0;

    ramp_means();
    run_frame("fwd", 0, -1, -1, 0, 0, 0);
    run_frame("mirror", 2, -1, -1, 0, 0, 0);
    check("mirror word31", 32'(got_q[31]), 32'h7F0);
    check("mirror word32", 32'(got_q[32]), 32'h7F0);
    run_frame("rev stall", 1, 10, -1, 0, 0, 0);
    run_frame("fwd drop", 0, -1, 7, 0, 0, 0);

    // start without en in IDLE must not produce words or a drop.
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); start = 1'b1; #1;
      if (we || busy || frame_drop) bad++;
    end
    @(negedge clk); start = 1'b0; #1;
    if (we || busy || frame_drop) bad++;
    check("idle start ignored", bad, 0);

    // en and start together only arm; the following start runs the frame.
    @(negedge clk); en = 1'b1; start = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); en = 1'b0; start = 1'b0; #1;
      if (we || busy || frame_drop) bad++;
    end
    check("en+start arms only", bad, 0);
    mean_r = $urandom; mean_g = $urandom; mean_b = $urandom;
    run_frame("pre-armed", 3, -1, -1, 0, 0, 1);

    for (int i = 0; i < 5; i++) begin
      mean_r = $urandom; mean_g = $urandom; mean_b = $urandom;
`ifdef LED_DIM_EN
      dim_v = 4'($urandom);
`endif
      run_frame($sformatf("rand%0d", i), int'($urandom_range(0, 3)), -1,
                (i == 2) ? int'($urandom_range(1, 20)) : -1, 1, 1, 0);
    end

`ifdef LED_DIM_EN
    dim_v = 4'h7;
    mean_r[3:0] = 4'hF; mean_g[3:0] = 4'h8; mean_b[3:0] = 4'h2;
    run_frame("dim solid", 3, -1, -1, 0, 0, 0);
    check("dim word0", 32'(got_q[0]), 32'h741);
    dim_v = 4'hF;
`endif

    // Reset during PACK after 5 accepted words aborts the frame.
    ramp_means();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0; start = 1'b1; mode = 2'b00;
    n = 0; guard = 0;
    while (n < 5 && guard < 50) begin
      @(negedge clk); start = 1'b0; #1;
      if (we) n++;
      guard++;
    end
    check("mid-pack words before reset", n, 5);
    rst = 1'b1;
    @(negedge clk); #1;
    check("mid reset we", 32'(we), 0);
    check("mid reset send_start", 32'(send_start), 0);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset fifo_data", 32'(fifo_data), 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (we || send_start || busy) bad++;
    end
    check("no resume after reset", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
